// File: rtl/complex_axpy_stream.sv
// complex_axpy_stream: streaming complex AXPY, result = second +/- first*c, NI lanes per beat
module complex_axpy_stream #(
  parameter int NI    = 8,
  parameter int EW    = 64,
  parameter int FRAC  = 16,
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] vec_len_i,
  input  logic             op_i,
  input  logic             conj_en_i,
  input  logic [EW-1:0]    constant_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [EW*NI-1:0] first_row_input_i,
  input  logic [EW*NI-1:0] second_row_input_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [EW*NI-1:0] result_o,
  output logic [NI-1:0]    result_mask_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             finish_o
);
  localparam int H  = EW / 2;
  localparam int PW = 2 * H + 2;
  localparam int IW = LEN_W + $clog2(NI) + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC - 1);
  localparam logic [LEN_W:0] NIW = (LEN_W + 1)'(NI);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, last_q, cnt_q;
  logic [LEN_W:0]   beats;
  logic             op_q, conj_q;
  logic [EW-1:0]    c_q;
  logic             v1_q, l1_q, v2_q, l2_q;
  logic [EW*NI-1:0] a1_q, b1_q, b2_q, p2_q, p_d, r_d;
  logic [NI-1:0]    m1_q, m2_q, m_d;
  logic             adv, in_fire, out_fire, last_in, drain_done, go;

  function automatic logic [H-1:0] sat_p(input logic [PW-1:0] v);
    return (&v[PW-1:H-1] | ~|v[PW-1:H-1]) ? v[H-1:0] : {v[PW-1], {(H-1){~v[PW-1]}}};
  endfunction

  function automatic logic [H-1:0] sat_s(input logic [H:0] v);
    return (v[H] == v[H-1]) ? v[H-1:0] : {v[H], {(H-1){~v[H]}}};
  endfunction

  assign adv        = !out_valid_o | out_ready_i;
  assign in_ready_o = (state_q == RUN) & adv;
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = out_valid_o & out_ready_i;
  assign last_in    = cnt_q == last_q;
  assign drain_done = (state_q == DRAIN) & out_fire & out_last_o;
  assign go         = start_i & ((state_q == IDLE) | (state_q == DONE) | drain_done);
  assign busy_o     = (state_q == RUN) | (state_q == DRAIN);
  assign finish_o   = state_q == DONE;
  assign beats      = ({1'b0, vec_len_i} + NIW - (LEN_W + 1)'(1)) / NIW;

  for (genvar j = 0; j < NI; j++) begin : g_lane
    localparam int HI = EW * (NI - j) - 1;
    logic signed [H-1:0]  ar, ai;
    logic signed [H:0]    cr, ci, cim;
    logic signed [PW-1:0] pr, pi, rr, ri;
    logic [H:0]           pre, pim, bre, bim, sr, si;
    assign ar  = a1_q[HI -: H];
    assign ai  = a1_q[HI-H -: H];
    assign cr  = {c_q[EW-1], c_q[EW-1:H]};
    assign cim = {c_q[H-1], c_q[H-1:0]};
    assign ci  = conj_q ? -cim : cim;
    assign pr  = PW'(ar) * PW'(cr) - PW'(ai) * PW'(ci);
    assign pi  = PW'(ar) * PW'(ci) + PW'(ai) * PW'(cr);
    assign rr  = (pr + RND) >>> FRAC;
    assign ri  = (pi + RND) >>> FRAC;
    assign p_d[HI -: EW] = {sat_p(rr), sat_p(ri)};
    assign pre = {p2_q[HI], p2_q[HI -: H]};
    assign pim = {p2_q[HI-H], p2_q[HI-H -: H]};
    assign bre = {b2_q[HI], b2_q[HI -: H]};
    assign bim = {b2_q[HI-H], b2_q[HI-H -: H]};
    assign sr  = op_q ? bre - pre : bre + pre;
    assign si  = op_q ? bim - pim : bim + pim;
    assign r_d[HI -: EW] = m2_q[NI-1-j] ? {sat_s(sr), sat_s(si)} : '0;
    assign m_d[NI-1-j] = IW'(cnt_q) * IW'(NI) + IW'(j) < IW'(len_q);
  end

  // next job phase from start, last input accepted and last output accepted
  always_comb begin
    state_d = state_q;
    if (go) state_d = (vec_len_i == '0) ? DONE : RUN;
    else if (state_q == RUN && in_fire && last_in) state_d = DRAIN;
    else if (drain_done) state_d = DONE;
  end

  // FSM state, latched job configuration and input beat counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      conj_q  <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        len_q  <= vec_len_i;
        last_q <= LEN_W'(beats - (LEN_W + 1)'(1));
        cnt_q  <= '0;
        op_q   <= op_i;
        conj_q <= conj_en_i;
        c_q    <= constant_i;
      end else if (in_fire && !last_in) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

  // three-stage datapath (operands, rounded products, sums) frozen as a whole on stall
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q <= 1'b0; l1_q <= 1'b0; a1_q <= '0; b1_q <= '0; m1_q <= '0;
      v2_q <= 1'b0; l2_q <= 1'b0; p2_q <= '0; b2_q <= '0; m2_q <= '0;
      out_valid_o <= 1'b0; out_last_o <= 1'b0; result_o <= '0; result_mask_o <= '0;
    end else if (adv) begin
      v1_q <= in_fire;
      l1_q <= in_fire & last_in;
      a1_q <= first_row_input_i;
      b1_q <= second_row_input_i;
      m1_q <= in_fire ? m_d : '0;
      v2_q <= v1_q;
      l2_q <= l1_q;
      p2_q <= p_d;
      b2_q <= b1_q;
      m2_q <= m1_q;
      out_valid_o   <= v2_q;
      out_last_o    <= l2_q;
      result_o      <= r_d;
      result_mask_o <= m2_q;
    end
  end
endmodule

// File: tb/tb_complex_axpy_stream.sv
// tb_complex_axpy_stream: scoreboard bench for complex_axpy_stream with NI=8, EW=64, FRAC=16
module tb_complex_axpy_stream;
  logic         clk, rst_n, start, op, conj_en, in_valid, in_ready;
  logic [15:0]  vec_len;
  logic [63:0]  constant;
  logic [511:0] first_row, second_row, result;
  logic         out_valid, out_ready, out_last, busy, finish;
  logic [7:0]   result_mask;
  int           total = 0, bad = 0;
  bit           tog = 0, pend_fin = 0;

  typedef struct {
    logic [511:0] r;
    logic [7:0]   m;
    logic         l;
  } exp_t;
  exp_t sb[$];

  complex_axpy_stream dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .vec_len_i(vec_len), .op_i(op),
    .conj_en_i(conj_en), .constant_i(constant), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .first_row_input_i(first_row), .second_row_input_i(second_row), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result), .result_mask_o(result_mask),
    .out_last_o(out_last), .busy_o(busy), .finish_o(finish)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] clamp(input logic signed [127:0] v);
    if (v > 128'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -128'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] c, input logic o, input logic cj);
    logic signed [127:0] ar, ai, br, bi, cr, ci, pr, pi, sr, si;
    ar = $signed(a[63:32]); ai = $signed(a[31:0]);
    br = $signed(b[63:32]); bi = $signed(b[31:0]);
    cr = $signed(c[63:32]); ci = $signed(c[31:0]);
    if (cj) ci = -ci;
    pr = ar * cr - ai * ci;
    pi = ar * ci + ai * cr;
    pr = $signed(clamp((pr + 128'sd32768) >>> 16));
    pi = $signed(clamp((pi + 128'sd32768) >>> 16));
    sr = o ? br - pr : br + pr;
    si = o ? bi - pi : bi + pi;
    return {clamp(sr), clamp(si)};
  endfunction

  function automatic logic [63:0] rand_c();
    logic [31:0] re, im;
    re = 32'($urandom_range(0, 262143)) - 32'h0002_0000;
    im = 32'($urandom_range(0, 262143)) - 32'h0002_0000;
    return {re, im};
  endfunction

  // out_ready: held high, or flipped every cycle while tog is set
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = tog ? ~out_ready : 1'b1;
    end
  end

  // output monitor: compares accepted beats against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend_fin) begin
        chk("finish_rise", finish, 1);
        pend_fin = 0;
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result, e.r);
          chk("mask", result_mask, e.m);
          chk("last", out_last, e.l);
          if (out_last) begin
            chk("finish_before", finish, 0);
            pend_fin = 1;
          end
        end
      end
    end
  end

  task automatic do_start(input int len, input logic [63:0] c, input logic o, input logic cj);
    start = 1; vec_len = 16'(len); constant = c; op = o; conj_en = cj;
    @(posedge clk);
    #1;
    start = 0;
    if (len == 0) begin
      chk("zero_finish", finish, 1);
      chk("zero_busy", busy, 0);
      chk("zero_no_valid", out_valid, 0);
    end else chk("start_busy", busy, 1);
  endtask

  task automatic send_beat(input logic [511:0] a, input logic [511:0] b,
                           input logic [511:0] e, input logic [7:0] m, input logic l);
    exp_t x;
    int n;
    in_valid = 1; first_row = a; second_row = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 1000);
    if (!in_ready) begin
      chk("in_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    x.r = e; x.m = m; x.l = l;
    sb.push_back(x);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic wait_finish();
    for (int i = 0; i < 2000 && !finish; i++) @(negedge clk);
    chk("finish_seen", finish, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int len, input logic [63:0] c, input logic o, input logic cj,
                         input int mode, input bit toggle, input int stop_after);
    int nb, k;
    logic [511:0] av, bv, ev;
    logic [7:0] mv;
    logic [63:0] la, lb;
    tog = toggle;
    do_start(len, c, o, cj);
    nb = (len + 7) / 8;
    for (int bt = 0; bt < nb && bt < stop_after; bt++) begin
      for (int j = 0; j < 8; j++) begin
        k = bt * 8 + j;
        case (mode)
          0: begin la = {32'(k), 32'h0}; lb = {32'd1, 32'd0}; end
          1: begin la = {32'h0001_0000, 32'h0}; lb = '0; end
          2: begin la = {32'h7FFF_FFFF, 32'h0}; lb = {32'h7FFF_FFFF, 32'h0}; end
          3: begin la = {32'h7FFF_FFFF, 32'h0}; lb = {32'h8000_0000, 32'h0}; end
          4: begin la = {32'd1, 32'h0}; lb = '0; end
          default: begin
            la = {32'($urandom_range(0, 33554431)) - 32'h0100_0000,
                  32'($urandom_range(0, 33554431)) - 32'h0100_0000};
            lb = {$urandom, $urandom};
          end
        endcase
        av[64*(8-j)-1 -: 64] = la;
        bv[64*(8-j)-1 -: 64] = lb;
        ev[64*(8-j)-1 -: 64] = (k < len) ? model(la, lb, c, o, cj) : 64'h0;
        mv[7-j] = k < len;
      end
      send_beat(av, bv, ev, mv, bt == nb - 1);
    end
    if (stop_after >= nb) begin
      wait_finish();
      chk("sb_empty", sb.size(), 0);
    end
    tog = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; vec_len = 0; op = 0; conj_en = 0; constant = 0;
    in_valid = 0; first_row = 0; second_row = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_mask", result_mask, 0);
    chk("rst_result", result, 0);
    chk("rst_last", out_last, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    run_job(16, {32'h0001_0000, 32'h0}, 0, 0, 0, 0, 1000);
    run_job(13, {32'h0, 32'h0001_0000}, 0, 1, 1, 0, 1000);
    run_job(8, {32'h0002_0000, 32'h0}, 0, 0, 2, 0, 1000);
    run_job(8, {32'h0002_0000, 32'h0}, 1, 0, 3, 0, 1000);
    run_job(8, {32'h0000_8000, 32'h0}, 0, 0, 4, 0, 1000);
    run_job(8, {32'hFFFF_8000, 32'h0}, 0, 0, 4, 0, 1000);
    run_job(64, rand_c(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5, 1, 1000);
    run_job(37, rand_c(), 1, 1, 5, 0, 1000);
    run_job(0, rand_c(), 0, 0, 5, 0, 1000);
    repeat (3) @(negedge clk);
    chk("zero_stays_done", finish, 1);
    @(posedge clk);
    #1;
    run_job(64, rand_c(), 0, 0, 5, 0, 3);
    #2;
    rst_n = 0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_finish", finish, 0);
    chk("abort_result", result, 0);
    chk("abort_mask", result_mask, 0);
    chk("abort_last", out_last, 0);
    sb.delete();
    in_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    run_job(20, rand_c(), 0, 1, 5, 0, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
